// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: lock FSM state type and round-robin index helper shared by stream_mux_rr
package stream_mux_pkg;
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  function automatic int rr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin priority search starting at ptr, plus the ptr register
module rr_arbiter import stream_mux_pkg::*; #(
  parameter int INS = 4,
  localparam int SW = $clog2(INS)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [INS-1:0] req,
  input  logic           adv,
  output logic [SW-1:0]  gnt,
  output logic           gnt_valid
);
  logic [SW-1:0] ptr;
  logic [SW:0]   j;
  // scan offsets high to low so the smallest offset from ptr is the one left standing
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    j = '0;
    for (int i = INS - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + (SW+1)'(i);
      j = (j >= (SW+1)'(INS)) ? j - (SW+1)'(INS) : j;
      if (req[j[SW-1:0]]) begin
        gnt = j[SW-1:0];
        gnt_valid = 1'b1;
      end
    end
  end
  // ptr moves past the winner only when the caller says the grant completes a turn
  always_ff @(posedge clk)
    if (!reset_n) ptr <= '0;
    else if (adv) ptr <= SW'(rr_next(int'(gnt), INS));
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 round-robin stream mux with registered output; packet lock under STREAM_MUX_LOCK_EN
module stream_mux_rr import stream_mux_pkg::*; #(
  parameter int INS = 4,
  parameter int W = 8,
  localparam int SW = $clog2(INS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [INS*W-1:0] in_data,
  input  logic [INS-1:0]   in_valid,
  output logic [INS-1:0]   in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [INS-1:0]   in_last,
`endif
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  output logic [SW-1:0]    out_sel,
  input  logic             out_ready
);
  logic           free, gnt_valid, adv;
  logic [SW-1:0]  gnt;
  logic [INS-1:0] req;
  logic [W-1:0]   ch [INS];
  for (genvar k = 0; k < INS; k++) begin : g_ch
    assign ch[k] = in_data[k*W +: W];
  end
  assign free = !out_valid || out_ready;
`ifdef STREAM_MUX_LOCK_EN
  lock_state_t   state;
  logic [SW-1:0] lock_ch;
  assign req = (reset_n && free) ? in_valid & ((state == LOCKED) ? INS'(1) << lock_ch : '1) : '0;
  assign adv = gnt_valid && in_last[gnt];
  // every accepted beat decides the lock: a non-last beat locks onto its channel, a last beat releases
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      lock_ch <= '0;
    end else if (gnt_valid) begin
      state <= in_last[gnt] ? IDLE : LOCKED;
      lock_ch <= gnt;
    end
`else
  assign req = (reset_n && free) ? in_valid : '0;
  assign adv = gnt_valid;
`endif
  assign in_ready = gnt_valid ? INS'(1) << gnt : '0;
  rr_arbiter #(.INS(INS)) u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .adv(adv),
    .gnt(gnt),
    .gnt_valid(gnt_valid)
  );
  // load on grant, drop valid once drained with nothing to load, hold while stalled
  always_ff @(posedge clk)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (gnt_valid) begin
      out_valid <= 1'b1;
      out_data <= ch[gnt];
      out_sel <= gnt;
    end else if (free) out_valid <= 1'b0;
endmodule
